// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      SA_IDLE,
      SA_SHIFT,
      SA_DONE
   } sa_state_e;

   localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/HalfAdder.sv
// Single-bit half adder: s = a ^ b, c = a & b.
module HalfAdder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell built from two HalfAdder instances.
module serial_fa_cell
   import serial_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_s1;
   logic w_c1;
   logic w_c2;

   HalfAdder u_ha0 (
      .a (a),
      .b (b),
      .s (w_s1),
      .c (w_c1)
   );

   HalfAdder u_ha1 (
      .a (w_s1),
      .b (ci),
      .s (s),
      .c (w_c2)
   );

   assign co = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock; {cout,sum} = a + b + cin.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sa_state_e        r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_s_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_s_nxt;

   serial_fa_cell u_cell (
      .a  (r_a_sr[0]),
      .b  (r_b_sr[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Only WIDTH-1 partial bits are stored; the final bit joins them directly into sum.
   assign w_s_nxt = {w_s, r_s_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SA_IDLE;
         r_a_sr  <= '0;
         r_b_sr  <= '0;
         r_s_sr  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            SA_IDLE, SA_DONE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SA_SHIFT;
               end else begin
                  r_state <= SA_IDLE;
               end
            end
            SA_SHIFT: begin
               r_s_sr  <= w_s_nxt[WIDTH-1:1];
               r_carry <= w_co;
               r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
               r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
               if (r_cnt == CNT_LAST) begin
                  r_sum   <= w_s_nxt;
                  r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                  r_ovf   <= r_carry ^ w_co;
`endif
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= SA_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= SA_IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a queue scoreboard of expected results.
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst   = 1'b1;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic         cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   t0    = 0;
   int   t1    = 0;
   int   bn    = 0;
   int   nd    = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      exp_t       e;
      logic [W:0] t;
      t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.s = t[W-1:0];
      e.c = t[W];
      e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
      a     = ia;
      b     = ib;
      cin   = ic;
      start = 1'b1;
      q.push_back(model(ia, ib, ic));
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
      t0    = cyc;
   endtask

   task automatic wait_done(output int busy_n);
      busy_n = 0;
      for (int k = 0; k < 4 * W && !done; k++) begin
         if (busy) busy_n++;
         @(negedge clk);
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         chk({tag, "_sum"}, 32'(sum), 32'(e.s));
         chk({tag, "_cout"}, 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
         chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
`endif
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // Basic add, busy window and latency
      start_op(8'h5A, 8'h3C, 1'b0);
      chk("busy_on", 32'(busy), 32'd1);
      chk("no_partial", 32'(sum), 32'd0);
      wait_done(bn);
      chk("busy_cycles", 32'(bn), 32'(W));
      chk("latency", 32'(cyc - t0), 32'(W));
      check_result("add_5a_3c");
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_off", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("sum_hold", 32'(sum), 32'h96);

      // Carry wrap cases
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(bn);
      check_result("add_ff_01");
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done(bn);
      check_result("add_ff_ff_1");

      // start during SHIFT is ignored
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      a     = 8'h11;
      b     = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(bn);
      chk("ign_latency", 32'(cyc - t0), 32'(W));
      check_result("ign_start");
      count_done(W + 4, nd);
      chk("ign_single_done", 32'(nd), 32'd0);
      chk("ign_sb_empty", 32'(q.size()), 32'd0);

      // Back-to-back start while in DONE
      start_op(8'h22, 8'h33, 1'b0);
      wait_done(bn);
      check_result("b2b_first");
      t1    = cyc;
      a     = 8'h01;
      b     = 8'h02;
      cin   = 1'b0;
      start = 1'b1;
      q.push_back(model(8'h01, 8'h02, 1'b0));
      @(negedge clk);
      start = 1'b0;
      chk("b2b_no_bubble", 32'(busy), 32'd1);
      wait_done(bn);
      chk("b2b_gap", 32'(cyc - t1), 32'(W + 1));
      check_result("b2b_second");

      // Asynchronous reset in the middle of SHIFT
      start_op(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_sum", 32'(sum), 32'd0);
      chk("arst_cout", 32'(cout), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      count_done(W + 4, nd);
      chk("arst_no_done", 32'(nd), 32'd0);
      start_op(8'h12, 8'h34, 1'b1);
      wait_done(bn);
      check_result("after_rst");

      // Two's-complement overflow boundaries
      start_op(8'h7F, 8'h01, 1'b0);
      wait_done(bn);
      check_result("ovf_7f_01");
      start_op(8'h80, 8'h80, 1'b0);
      wait_done(bn);
      check_result("ovf_80_80");
      start_op(8'h05, 8'hFB, 1'b0);
      wait_done(bn);
      check_result("ovf_05_fb");

      // Random operands
      for (int i = 0; i < 6; i++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         wait_done(bn);
         check_result("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
